jk_cmd_driver: RTL and testbench

JK_CMD_DRIVER -- requirements
Module: jk_cmd_driver

---
 rtl/jk_cmd_driver_if.sv | 12 +
 rtl/jk_cmd_driver.sv | 111 +++++++++++
 tb/tb_jk_cmd_driver.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/jk_cmd_driver_if.sv
// rtl/jk_cmd_driver_if.sv - command channel into the JK command driver
interface jk_cmd_driver_if #(
    parameter int REP_W = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [REP_W-1:0] cmd_rep;

    modport master (output cmd_valid, output cmd_op, output cmd_rep, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_op, input cmd_rep, output cmd_ready);
endinterface

// File: rtl/jk_cmd_driver.sv
// rtl/jk_cmd_driver.sv - queued command driver for an external JK flip-flop
// Commands drive J/K for rep+1 cycles, then Q/Qn are checked against a shadow model.
module jk_cmd_driver #(
    parameter int DEPTH = 4,
    parameter int REP_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    jk_cmd_driver_if.slave    cmd,
    output logic              J,
    output logic              K,
    input  logic              q_in,
    input  logic              qn_in,
    output logic              busy,
    output logic              done,
    output logic              err,
    input  logic              err_clr
);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = REP_W + 2;
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, DRIVE, CHECK} state_t;

    logic [EW-1:0]    mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    state_t           state;
    logic [1:0]       op;
    logic [REP_W-1:0] cnt;
    logic             exp_q;
    logic             push;
    logic             pop;
    logic             mismatch;

    assign cmd.cmd_ready = (count != FULL);
    assign push          = cmd.cmd_valid && cmd.cmd_ready;
    assign pop           = (state == IDLE) && (count != '0);
    assign mismatch      = (q_in != exp_q) || (qn_in == q_in);

    assign J    = (state == DRIVE) & op[1];
    assign K    = (state == DRIVE) & op[0];
    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {cmd.cmd_op, cmd.cmd_rep};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // exp_q shadows the downstream flop, which also resets to Q=0
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            op    <= '0;
            cnt   <= '0;
            exp_q <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        {op, cnt} <= mem[rd_ptr];
                        state     <= DRIVE;
                    end
                end
                DRIVE: begin
                    case (op)
                        2'b01:   exp_q <= 1'b0;
                        2'b10:   exp_q <= 1'b1;
                        2'b11:   exp_q <= ~exp_q;
                        default: exp_q <= exp_q;
                    endcase
                    if (cnt == '0)
                        state <= CHECK;
                    else
                        cnt <= cnt - 1'b1;
                end
                CHECK: begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
            if (state == CHECK && mismatch)
                err <= 1'b1;
            else if (err_clr)
                err <= 1'b0;
        end
    end
endmodule

// File: tb/tb_jk_cmd_driver.sv
// tb/tb_jk_cmd_driver.sv - self-checking bench for jk_cmd_driver
module tb_jk_cmd_driver;
    localparam int DEPTH = 4;
    localparam int REP_W = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic J, K, busy, done, err;
    logic err_clr = 1'b0;
    logic q_in, qn_in;
    logic q_ff;
    int   q_mode = 0;
    bit   chk_en = 0;

    int nchecks = 0;
    int npass = 0;
    int jk_cnt = 0;
    int done_cnt = 0;

    jk_cmd_driver_if #(.REP_W(REP_W)) cif ();

    jk_cmd_driver #(.DEPTH(DEPTH), .REP_W(REP_W)) dut (
        .clk(clk), .reset(reset), .cmd(cif),
        .J(J), .K(K), .q_in(q_in), .qn_in(qn_in),
        .busy(busy), .done(done), .err(err), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    // Ideal downstream JK flop; q_mode injects faults on the feedback
    always @(posedge clk or posedge reset) begin
        if (reset) q_ff <= 1'b0;
        else case ({J, K})
            2'b01:   q_ff <= 1'b0;
            2'b10:   q_ff <= 1'b1;
            2'b11:   q_ff <= ~q_ff;
            default: q_ff <= q_ff;
        endcase
    end
    assign q_in  = (q_mode == 1) ? 1'b0 : (q_mode == 2) ? 1'b1 : q_ff;
    assign qn_in = (q_mode == 0) ? ~q_ff : 1'b1;

    always @(negedge clk) begin
        if (J | K) jk_cnt <= jk_cnt + 1;
        if (done)  done_cnt <= done_cnt + 1;
    end

    // Behavioural model: a command queue plus one active command walking slots 1..rep+2
    logic [1:0] mq_op[$];
    int         mq_rep[$];
    bit         m_active, m_exp, m_done, m_err;
    logic [1:0] m_op;
    int         m_rep, m_t;

    task automatic model_clear();
        mq_op.delete(); mq_rep.delete();
        m_active = 0; m_exp = 0; m_done = 0; m_err = 0; m_t = 0; m_op = 2'b00; m_rep = 0;
    endtask

    task automatic model_step();
        bit push_ok, mism;
        push_ok = cif.cmd_valid && (mq_op.size() < DEPTH);
        mism = 0;
        m_done = 0;
        if (m_active) begin
            if (m_t == m_rep + 2) begin
                mism = (q_in !== m_exp) || (qn_in === q_in);
                m_done = 1;
                m_active = 0;
            end else begin
                if (m_op == 2'b01) m_exp = 0;
                else if (m_op == 2'b10) m_exp = 1;
                else if (m_op == 2'b11) m_exp = !m_exp;
                m_t++;
            end
        end else if (mq_op.size() > 0) begin
            m_op = mq_op.pop_front();
            m_rep = mq_rep.pop_front();
            m_active = 1;
            m_t = 1;
        end
        if (mism) m_err = 1;
        else if (err_clr) m_err = 0;
        if (push_ok) begin
            mq_op.push_back(cif.cmd_op);
            mq_rep.push_back(int'(cif.cmd_rep));
        end
    endtask

    initial begin
        model_clear();
        forever begin
            @(posedge clk or posedge reset);
            if (reset) model_clear();
            else model_step();
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    initial begin
        bit drv;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                drv = m_active && (m_t <= m_rep + 1);
                chk("cyc_J", J, drv & m_op[1]);
                chk("cyc_K", K, drv & m_op[0]);
                chk("cyc_busy", busy, m_active);
                chk("cyc_done", done, m_done);
                chk("cyc_err", err, m_err);
                chk("cyc_ready", cif.cmd_ready, mq_op.size() < DEPTH);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    task automatic send(input logic [1:0] op, input int rep);
        cif.cmd_valid = 1'b1;
        cif.cmd_op = op;
        cif.cmd_rep = REP_W'(rep);
        @(posedge clk); #2;
        cif.cmd_valid = 1'b0;
    endtask

    task automatic wait_quiet(input int budget);
        int n = 0;
        while ((m_active || mq_op.size() > 0) && n < budget) begin
            idle(1);
            n++;
        end
        if (n >= budget) begin
            nchecks++;
            $display("FAIL wait_quiet: timeout after %0d cycles", n);
        end
        idle(2);
    endtask

    initial begin
        int d0, j0;
        cif.cmd_valid = 1'b0;
        cif.cmd_op = 2'b00;
        cif.cmd_rep = '0;
        #1 reset = 1'b1;
        #2;
        chk("rst_J", J, 0);
        chk("rst_K", K, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_ready", cif.cmd_ready, 1);
        @(posedge clk); @(posedge clk); #2;
        reset = 1'b0;
        chk_en = 1;

        // set, rep=0
        send(2'b10, 0);
        chk("set_lat_J0", J, 0);
        idle(1);
        chk("set_J", J, 1);
        chk("set_K", K, 0);
        idle(1);
        chk("set_check_J", J, 0);
        chk("set_q", q_in, 1);
        idle(1);
        chk("set_done", done, 1);
        chk("set_err", err, 0);
        wait_quiet(50);

        // bring Q back to 0, then toggle rep=2
        send(2'b01, 0);
        wait_quiet(50);
        send(2'b11, 2);
        idle(1);
        chk("tog_J1", J, 1);
        chk("tog_K1", K, 1);
        idle(2);
        chk("tog_J3", J, 1);
        idle(1);
        chk("tog_J_off", J, 0);
        chk("tog_q", q_in, 1);
        idle(1);
        chk("tog_done", done, 1);
        chk("tog_err", err, 0);
        wait_quiet(50);

        // fill FIFO behind a rep=15 command; extra push is dropped
        d0 = done_cnt;
        send(2'b11, 15);
        idle(1);
        send(2'b10, 0);
        send(2'b01, 1);
        send(2'b11, 2);
        send(2'b00, 1);
        chk("full_ready", cif.cmd_ready, 0);
        send(2'b10, 3);
        chk("full_ready2", cif.cmd_ready, 0);
        wait_quiet(200);
        chk("full_dones", done_cnt - d0, 5);

        // forced Q=0 mismatch, then err_clr coincident with a new mismatch
        q_mode = 1;
        send(2'b10, 0);
        idle(2);
        idle(1);
        chk("m1_err", err, 1);
        chk("m1_done", done, 1);
        send(2'b10, 0);
        idle(2);
        err_clr = 1'b1;
        idle(1);
        err_clr = 1'b0;
        chk("m2_err_set_wins", err, 1);
        q_mode = 0;
        err_clr = 1'b1;
        idle(1);
        err_clr = 1'b0;
        chk("m2_err_cleared", err, 0);
        wait_quiet(50);

        // Qn == Q mismatch
        q_mode = 2;
        send(2'b10, 0);
        idle(3);
        chk("qn_err", err, 1);
        q_mode = 0;
        err_clr = 1'b1;
        idle(1);
        err_clr = 1'b0;
        chk("qn_err_cleared", err, 0);
        wait_quiet(50);

        // reset in 3rd drive cycle of toggle rep=7 with 2 queued
        send(2'b11, 7);
        send(2'b01, 0);
        send(2'b10, 0);
        idle(1);
        chk("abort_pre_J", J, 1);
        reset = 1'b1;
        #1;
        chk("abort_J", J, 0);
        chk("abort_K", K, 0);
        chk("abort_ready", cif.cmd_ready, 1);
        chk("abort_busy", busy, 0);
        idle(1);
        reset = 1'b0;
        d0 = done_cnt;
        j0 = jk_cnt;
        idle(20);
        chk("abort_no_done", done_cnt - d0, 0);
        chk("abort_no_jk", jk_cnt - j0, 0);

        chk_en = 0;
        $display("%0d/%0d checks passed", npass, nchecks);
        $finish;
    end
endmodule
